// File: rtl/dest_tracking_unit.sv
// Destination-tag tracker for the EXE/MEM/WB stages.
// Drives forwarding tags, the ID-stage RAW stall and a saturating stall counter.
//
// Ports:
//   clk, rst (async active-low)          clock and reset
//   mode                                 forwarding enable
//   ID_valid, ID_Dest, ID_WB_EN,
//   ID_MEM_R_EN, src1, src2, Two_src     instruction currently in ID
//   freeze, flush                        pipeline hold / branch squash
//   EXE_*, Mem_*, WB_*                   tags held in each tracked stage
//   hazard_detected                      ID must stall this cycle
//   stall_count                          saturating stall-cycle count
module dest_tracking_unit #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mode,
    input  logic             ID_valid,
    input  logic [3:0]       ID_Dest,
    input  logic             ID_WB_EN,
    input  logic             ID_MEM_R_EN,
    input  logic [3:0]       src1,
    input  logic [3:0]       src2,
    input  logic             Two_src,
    input  logic             freeze,
    input  logic             flush,
    output logic [3:0]       EXE_Dest,
    output logic             EXE_WB_EN,
    output logic             EXE_MEM_R_EN,
    output logic [3:0]       Mem_Dest,
    output logic             Mem_WB_EN,
    output logic [3:0]       WB_Dest,
    output logic             WB_WB_EN,
    output logic             hazard_detected,
    output logic [CNT_W-1:0] stall_count
);

    logic match_exe;
    logic match_mem;
    logic fwd_hazard;
    logic nofwd_hazard;
    logic raw_hazard;
    logic bubble;

    // src2 only participates when the instruction actually reads it
    assign match_exe = (src1 == EXE_Dest) ||
                       (Two_src && (src2 == EXE_Dest));
    assign match_mem = (src1 == Mem_Dest) ||
                       (Two_src && (src2 == Mem_Dest));

    // With forwarding only a load in EXE cannot be bypassed in time.
    // WB never stalls: the register file writes before ID reads.
    assign fwd_hazard   = match_exe && EXE_MEM_R_EN;
    assign nofwd_hazard = (match_exe && EXE_WB_EN) ||
                          (match_mem && Mem_WB_EN);

    assign raw_hazard      = ID_valid &&
                             (mode ? fwd_hazard : nofwd_hazard);
    assign hazard_detected = raw_hazard && !flush;

    assign bubble = flush || hazard_detected || !ID_valid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            EXE_Dest     <= 4'd0;
            EXE_WB_EN    <= 1'b0;
            EXE_MEM_R_EN <= 1'b0;
            Mem_Dest     <= 4'd0;
            Mem_WB_EN    <= 1'b0;
            WB_Dest      <= 4'd0;
            WB_WB_EN     <= 1'b0;
            stall_count  <= '0;
        end else if (!freeze) begin
            WB_Dest   <= Mem_Dest;
            WB_WB_EN  <= Mem_WB_EN;
            Mem_Dest  <= EXE_Dest;
            Mem_WB_EN <= EXE_WB_EN;
            if (bubble) begin
                EXE_Dest     <= 4'd0;
                EXE_WB_EN    <= 1'b0;
                EXE_MEM_R_EN <= 1'b0;
            end else begin
                EXE_Dest     <= ID_Dest;
                EXE_WB_EN    <= ID_WB_EN;
                EXE_MEM_R_EN <= ID_MEM_R_EN;
            end
            if (hazard_detected && (stall_count != {CNT_W{1'b1}}))
                stall_count <= stall_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_dest_tracking_unit.sv
// Directed self-checking bench for dest_tracking_unit.
// A second instance with CNT_W = 4 exercises counter saturation.
module tb_dest_tracking_unit;

    logic        clk;
    logic        rst;
    logic        mode;
    logic        ID_valid;
    logic [3:0]  ID_Dest;
    logic        ID_WB_EN;
    logic        ID_MEM_R_EN;
    logic [3:0]  src1;
    logic [3:0]  src2;
    logic        Two_src;
    logic        freeze;
    logic        flush;

    logic [3:0]  EXE_Dest;
    logic        EXE_WB_EN;
    logic        EXE_MEM_R_EN;
    logic [3:0]  Mem_Dest;
    logic        Mem_WB_EN;
    logic [3:0]  WB_Dest;
    logic        WB_WB_EN;
    logic        hazard_detected;
    logic [15:0] stall_count;

    logic [3:0]  s_EXE_Dest;
    logic        s_EXE_WB_EN;
    logic        s_EXE_MEM_R_EN;
    logic [3:0]  s_Mem_Dest;
    logic        s_Mem_WB_EN;
    logic [3:0]  s_WB_Dest;
    logic        s_WB_WB_EN;
    logic        s_hazard;
    logic [3:0]  s_stall_count;

    int checks;
    int fails;

    dest_tracking_unit #(.CNT_W(16)) u_dut (
        .clk(clk), .rst(rst), .mode(mode), .ID_valid(ID_valid),
        .ID_Dest(ID_Dest), .ID_WB_EN(ID_WB_EN),
        .ID_MEM_R_EN(ID_MEM_R_EN), .src1(src1), .src2(src2),
        .Two_src(Two_src), .freeze(freeze), .flush(flush),
        .EXE_Dest(EXE_Dest), .EXE_WB_EN(EXE_WB_EN),
        .EXE_MEM_R_EN(EXE_MEM_R_EN), .Mem_Dest(Mem_Dest),
        .Mem_WB_EN(Mem_WB_EN), .WB_Dest(WB_Dest), .WB_WB_EN(WB_WB_EN),
        .hazard_detected(hazard_detected), .stall_count(stall_count)
    );

    dest_tracking_unit #(.CNT_W(4)) u_sat (
        .clk(clk), .rst(rst), .mode(mode), .ID_valid(ID_valid),
        .ID_Dest(ID_Dest), .ID_WB_EN(ID_WB_EN),
        .ID_MEM_R_EN(ID_MEM_R_EN), .src1(src1), .src2(src2),
        .Two_src(Two_src), .freeze(freeze), .flush(flush),
        .EXE_Dest(s_EXE_Dest), .EXE_WB_EN(s_EXE_WB_EN),
        .EXE_MEM_R_EN(s_EXE_MEM_R_EN), .Mem_Dest(s_Mem_Dest),
        .Mem_WB_EN(s_Mem_WB_EN), .WB_Dest(s_WB_Dest),
        .WB_WB_EN(s_WB_WB_EN),
        .hazard_detected(s_hazard), .stall_count(s_stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [3:0] d,
                          input logic we, input logic ld,
                          input logic [3:0] s1, input logic [3:0] s2,
                          input logic two);
        ID_valid    = v;
        ID_Dest     = d;
        ID_WB_EN    = we;
        ID_MEM_R_EN = ld;
        src1        = s1;
        src2        = s2;
        Two_src     = two;
    endtask

    task automatic do_reset();
        set_id(1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
        freeze = 1'b0;
        flush  = 1'b0;
        rst    = 1'b0;
        #2;
        rst    = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        set_id(1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
        mode = 1'b1; freeze = 1'b0; flush = 1'b0;
        rst = 1'b0;
        #3;
        checks++;
        if ({EXE_Dest, EXE_WB_EN, EXE_MEM_R_EN, Mem_Dest, Mem_WB_EN,
             WB_Dest, WB_WB_EN} !== 15'd0) begin
            fails++;
            $display("FAIL reset_tags: got %h expected 0",
                {EXE_Dest, EXE_WB_EN, EXE_MEM_R_EN, Mem_Dest, Mem_WB_EN,
                 WB_Dest, WB_WB_EN});
        end
        checks++;
        if (hazard_detected !== 1'b0) begin
            fails++;
            $display("FAIL reset_hazard: got %b expected 0", hazard_detected);
        end
        checks++;
        if (stall_count !== 16'd0) begin
            fails++;
            $display("FAIL reset_count: got %0d expected 0", stall_count);
        end
        step();
        rst = 1'b1;
        #1;
    endtask

    task automatic test_reset_midstream();
        do_reset();
        mode = 1'b1;
        set_id(1'b1, 4'd3, 1'b1, 1'b1, 4'd0, 4'd0, 1'b0);
        step();
        set_id(1'b1, 4'd4, 1'b1, 1'b0, 4'd3, 4'd0, 1'b0);
        step();
        step();
        set_id(1'b1, 4'd5, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0);
        step();
        set_id(1'b1, 4'd6, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0);
        step();
        checks++;
        if ({EXE_Dest, Mem_Dest, WB_Dest} !== 12'h654 ||
            stall_count !== 16'd1) begin
            fails++;
            $display("FAIL mid_preload: got tags %h cnt %0d expected 654 cnt 1",
                {EXE_Dest, Mem_Dest, WB_Dest}, stall_count);
        end
        #1;
        rst = 1'b0;
        #1;
        checks++;
        if ({EXE_Dest, EXE_WB_EN, EXE_MEM_R_EN, Mem_Dest, Mem_WB_EN,
             WB_Dest, WB_WB_EN} !== 15'd0) begin
            fails++;
            $display("FAIL mid_reset_tags: got %h expected 0",
                {EXE_Dest, EXE_WB_EN, EXE_MEM_R_EN, Mem_Dest, Mem_WB_EN,
                 WB_Dest, WB_WB_EN});
        end
        checks++;
        if (stall_count !== 16'd0) begin
            fails++;
            $display("FAIL mid_reset_count: got %0d expected 0", stall_count);
        end
        rst = 1'b1;
        set_id(1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
    endtask

    task automatic test_load_use();
        do_reset();
        mode = 1'b1;
        set_id(1'b1, 4'd3, 1'b1, 1'b1, 4'd0, 4'd0, 1'b0);
        step();
        set_id(1'b1, 4'd4, 1'b1, 1'b0, 4'd3, 4'd0, 1'b0);
        #1;
        checks++;
        if (hazard_detected !== 1'b1) begin
            fails++;
            $display("FAIL lu_hazard: got %b expected 1", hazard_detected);
        end
        step();
        checks++;
        if (EXE_Dest !== 4'd0 || EXE_WB_EN !== 1'b0 ||
            EXE_MEM_R_EN !== 1'b0) begin
            fails++;
            $display("FAIL lu_bubble: got %h/%b/%b expected 0/0/0",
                EXE_Dest, EXE_WB_EN, EXE_MEM_R_EN);
        end
        checks++;
        if (Mem_Dest !== 4'd3 || Mem_WB_EN !== 1'b1) begin
            fails++;
            $display("FAIL lu_mem: got %h/%b expected 3/1",
                Mem_Dest, Mem_WB_EN);
        end
        checks++;
        if (hazard_detected !== 1'b0 || stall_count !== 16'd1) begin
            fails++;
            $display("FAIL lu_clear: got haz %b cnt %0d expected 0 cnt 1",
                hazard_detected, stall_count);
        end
        step();
        checks++;
        if (EXE_Dest !== 4'd4 || Mem_Dest !== 4'd0 || WB_Dest !== 4'd3) begin
            fails++;
            $display("FAIL lu_advance: got %h%h%h expected 403",
                EXE_Dest, Mem_Dest, WB_Dest);
        end
        set_id(1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
    endtask

    task automatic test_alu_dep();
        do_reset();
        mode = 1'b1;
        set_id(1'b1, 4'd5, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0);
        step();
        set_id(1'b1, 4'd6, 1'b1, 1'b0, 4'd1, 4'd5, 1'b1);
        #1;
        checks++;
        if (hazard_detected !== 1'b0) begin
            fails++;
            $display("FAIL alu_fwd_exe: got %b expected 0", hazard_detected);
        end
        step();
        checks++;
        if (hazard_detected !== 1'b0 || EXE_Dest !== 4'd6) begin
            fails++;
            $display("FAIL alu_fwd_mem: got haz %b exe %h expected 0 6",
                hazard_detected, EXE_Dest);
        end

        do_reset();
        mode = 1'b0;
        set_id(1'b1, 4'd5, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0);
        step();
        set_id(1'b1, 4'd6, 1'b1, 1'b0, 4'd1, 4'd5, 1'b1);
        #1;
        checks++;
        if (hazard_detected !== 1'b1) begin
            fails++;
            $display("FAIL nofwd_exe: got %b expected 1", hazard_detected);
        end
        step();
        checks++;
        if (hazard_detected !== 1'b1 || Mem_Dest !== 4'd5) begin
            fails++;
            $display("FAIL nofwd_mem: got haz %b mem %h expected 1 5",
                hazard_detected, Mem_Dest);
        end
        step();
        checks++;
        if (hazard_detected !== 1'b0 || stall_count !== 16'd2) begin
            fails++;
            $display("FAIL nofwd_done: got haz %b cnt %0d expected 0 cnt 2",
                hazard_detected, stall_count);
        end

        do_reset();
        mode = 1'b0;
        set_id(1'b1, 4'd5, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0);
        step();
        set_id(1'b1, 4'd6, 1'b1, 1'b0, 4'd1, 4'd5, 1'b0);
        #1;
        checks++;
        if (hazard_detected !== 1'b0) begin
            fails++;
            $display("FAIL one_src_exe: got %b expected 0", hazard_detected);
        end
        step();
        checks++;
        if (hazard_detected !== 1'b0 || stall_count !== 16'd0) begin
            fails++;
            $display("FAIL one_src_mem: got haz %b cnt %0d expected 0 cnt 0",
                hazard_detected, stall_count);
        end
        set_id(1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
    endtask

    task automatic test_freeze();
        do_reset();
        mode = 1'b1;
        set_id(1'b1, 4'd9, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0);
        step();
        set_id(1'b1, 4'd8, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0);
        step();
        set_id(1'b1, 4'd7, 1'b1, 1'b1, 4'd0, 4'd0, 1'b0);
        step();
        set_id(1'b1, 4'd2, 1'b1, 1'b0, 4'd7, 4'd0, 1'b0);
        freeze = 1'b1;
        for (int i = 0; i < 4; i++) step();
        checks++;
        if ({EXE_Dest, Mem_Dest, WB_Dest} !== 12'h789 ||
            EXE_MEM_R_EN !== 1'b1) begin
            fails++;
            $display("FAIL freeze_tags: got %h ld %b expected 789 ld 1",
                {EXE_Dest, Mem_Dest, WB_Dest}, EXE_MEM_R_EN);
        end
        checks++;
        if (hazard_detected !== 1'b1 || stall_count !== 16'd0) begin
            fails++;
            $display("FAIL freeze_hold: got haz %b cnt %0d expected 1 cnt 0",
                hazard_detected, stall_count);
        end
        freeze = 1'b0;
        step();
        checks++;
        if (stall_count !== 16'd1 || Mem_Dest !== 4'd7 || EXE_Dest !== 4'd0) begin
            fails++;
            $display("FAIL thaw: got cnt %0d mem %h exe %h expected 1 7 0",
                stall_count, Mem_Dest, EXE_Dest);
        end
        set_id(1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
    endtask

    task automatic test_flush_vs_hazard();
        do_reset();
        mode = 1'b1;
        set_id(1'b1, 4'd3, 1'b1, 1'b1, 4'd0, 4'd0, 1'b0);
        step();
        set_id(1'b1, 4'd4, 1'b1, 1'b0, 4'd3, 4'd0, 1'b0);
        flush = 1'b1;
        #1;
        checks++;
        if (hazard_detected !== 1'b0) begin
            fails++;
            $display("FAIL flush_haz: got %b expected 0", hazard_detected);
        end
        step();
        flush = 1'b0;
        checks++;
        if (EXE_Dest !== 4'd0 || EXE_WB_EN !== 1'b0 || Mem_Dest !== 4'd3 ||
            stall_count !== 16'd0) begin
            fails++;
            $display("FAIL flush_bubble: got exe %h/%b mem %h cnt %0d expected 0/0 3 0",
                EXE_Dest, EXE_WB_EN, Mem_Dest, stall_count);
        end
        set_id(1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
    endtask

    task automatic test_saturation();
        do_reset();
        mode = 1'b1;
        // Self-dependent load: stalls every other cycle.
        set_id(1'b1, 4'd3, 1'b1, 1'b1, 4'd3, 4'd0, 1'b0);
        for (int i = 0; i < 50; i++) begin
            step();
            if (i == 27) begin
                checks++;
                if (s_stall_count !== 4'd14 || stall_count !== 16'd14) begin
                    fails++;
                    $display("FAIL sat_mid: got %0d/%0d expected 14/14",
                        s_stall_count, stall_count);
                end
            end
        end
        checks++;
        if (s_stall_count !== 4'd15) begin
            fails++;
            $display("FAIL sat_cap: got %0d expected 15", s_stall_count);
        end
        checks++;
        if (stall_count !== 16'd25) begin
            fails++;
            $display("FAIL sat_wide: got %0d expected 25", stall_count);
        end
        set_id(1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
    endtask

    initial begin
        checks = 0;
        fails  = 0;
        rst    = 1'b0;
        mode   = 1'b1;
        freeze = 1'b0;
        flush  = 1'b0;
        set_id(1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
        test_reset();
        test_reset_midstream();
        test_load_use();
        test_alu_dep();
        test_freeze();
        test_flush_vs_hazard();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures",
            checks, fails);
        $finish;
    end

endmodule

// File: doc/dest_tracking_unit.md
# dest_tracking_unit

- Tracks the destination-register tag of every in-flight instruction through the EXE, MEM and WB pipeline stages.
- Drives the Mem_Dest/Mem_WB_EN and WB_Dest/WB_WB_EN tags that the forwarding unit consumes.
- Raises the ID-stage hazard stall: load-use only when forwarding is on, any in-flight RAW match when it is off.
- Sits beside the ID/EXE, EXE/MEM and MEM/WB pipeline registers and keeps a saturating stall-cycle counter for performance measurement.

## Interface
Parameters:
- CNT_W, 16, width of the stall-cycle counter

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- mode  in  1  forwarding enable, same meaning as the forwarding unit's mode
- ID_valid  in  1  ID stage holds a real instruction
- ID_Dest  in  4  destination register of the ID instruction
- ID_WB_EN  in  1  ID instruction writes the register file
- ID_MEM_R_EN  in  1  ID instruction is a load
- src1  in  4  first source register of the ID instruction, always used
- src2  in  4  second source register of the ID instruction
- Two_src  in  1  src2 is used by the ID instruction
- freeze  in  1  memory-stage busy; whole tracked pipeline holds
- flush  in  1  branch taken; ID instruction is squashed
- EXE_Dest  out  4  tag in EXE
- EXE_WB_EN  out  1  EXE instruction writes back
- EXE_MEM_R_EN  out  1  EXE instruction is a load
- Mem_Dest  out  4  tag in MEM
- Mem_WB_EN  out  1  MEM instruction writes back
- WB_Dest  out  4  tag in WB
- WB_WB_EN  out  1  WB instruction writes back
- hazard_detected  out  1  ID must stall this cycle (combinational)
- stall_count  out  CNT_W  saturating count of stall cycles

## Operation
- **Stage registers:** three stage records: EXE {Dest, WB_EN, MEM_R_EN}, MEM {Dest, WB_EN}, WB {Dest, WB_EN}.
- **Match terms:**
  - m(s, D, EN) = (s == D) && EN.
  - A src2 match counts only when Two_src = 1.
- **mode = 1 (forwarding on):**
  - raw_hazard = ID_valid && (m(src1, EXE_Dest, EXE_MEM_R_EN) || (Two_src && m(src2, EXE_Dest, EXE_MEM_R_EN))).
  - ALU results forward from MEM/WB; only a load in EXE stalls.
- **mode = 0 (forwarding off):**
  - raw_hazard = ID_valid && any match of src1/src2 (src2 gated by Two_src) against (EXE_Dest, EXE_WB_EN) or (Mem_Dest, Mem_WB_EN).
- **WB stage never causes a hazard:** the register file writes on the falling edge, before ID reads.
- **hazard_detected** = raw_hazard && !flush. A squashed instruction never stalls.
- **Stage advance** (rising edge, freeze = 0), applied simultaneously:
  - WB ← MEM.
  - MEM ← EXE.
  - EXE ← bubble {0, 0, 0} if flush || hazard_detected || !ID_valid.
  - Otherwise EXE ← {ID_Dest, ID_WB_EN, ID_MEM_R_EN}.
- **freeze = 1:** all three stages hold, regardless of flush and hazard.
- **stall_count:**
  - Increments by 1 on each rising edge where hazard_detected && !freeze.
  - Saturates at all-ones.
  - Frozen cycles are not counted.
- **Priority per edge:** reset > freeze > flush > hazard > normal advance.
- **Tag 15 (PC):** treated as an ordinary 4-bit tag, with no special case.

## Timing
- **Reset (rst = 0):** asynchronous, takes effect immediately.
  - All stage fields go to 0, so every *_Dest = 0 and every *_WB_EN/*_MEM_R_EN = 0.
  - stall_count = 0.
  - hazard_detected follows combinationally and is 0 while the stages are empty.
- **Reset release:** the first capture is on the first rising edge with rst = 1.
- **Reset mid-operation:** all in-flight tags are discarded; no partial state survives.
- **Latency:** a tag accepted at edge N is visible as:
  - EXE_* after edge N.
  - Mem_* after edge N+1.
  - WB_* after edge N+2.
  - Each frozen edge adds one cycle.
- **hazard_detected:** purely combinational from current stage state and ID inputs; no registered delay.
- **Load-use stall with forwarding:** exactly one cycle.
  - The bubble enters EXE, the load moves to MEM, and the match clears.
- **Stall without forwarding:** up to two cycles, until the producer leaves MEM.
- **Simultaneous flush and hazard:** flush wins; hazard_detected = 0, a bubble enters EXE and the counter does not increment.
- **Simultaneous freeze and hazard:** hazard_detected stays asserted; stages and counter hold.

## Test plan
- **Reset mid-stream:** load three tags, then pulse rst low asynchronously between edges.
  - Required: all outputs 0 immediately; stall_count = 0.
- **Load-use, mode = 1:**
  - Stimulus: ID = LDR R3 (Dest = 3, WB_EN = 1, MEM_R_EN = 1), next cycle ID src1 = 3.
  - Required: hazard_detected = 1 for exactly 1 cycle; EXE_* = 0 the following cycle; Mem_Dest = 3; stall_count = 1.
- **ALU dependency:**
  - mode = 1: ID = ADD R5, then src2 = 5 with Two_src = 1 → hazard_detected never asserts.
  - mode = 0, same stimulus → hazard for 2 cycles; stall_count = 2.
  - mode = 0 with Two_src = 0 → no hazard.
- **Freeze:** hold freeze = 1 for 4 cycles with tags 7/8/9 in EXE/MEM/WB.
  - Required: all tags unchanged; stall_count unchanged even with a pending hazard.
- **Flush vs hazard:** flush = 1 in a cycle that has a load-use match.
  - Required: hazard_detected = 0; EXE bubble; no count.
- **Saturation:** CNT_W = 4; force 20 hazard cycles.
  - Required: stall_count stops at 15.
